// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: rotates a one-hot column drive on a divided
// scan tick, debounces a single-row hit on the frozen column, and reports
// the accepted key code with a one-cycle strobe plus a held flag.
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [3:0] key_data,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic [2:0]      col_q, col_d;
  logic [3:0]      row_q, row_d;
  logic [CW-1:0]   match_q, match_d, rel_q, rel_d;
  logic [3:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            pressed_q;

  logic            tick;
  logic            row_onehot;
  logic            row_same;
  logic            row_idle;
  logic [CW-1:0]   match_inc, rel_inc;
  logic [2:0]      col_rot;

  // Code = row*3 + col + 1 from one-hot row/column patterns.
  function automatic logic [3:0] key_code(input logic [3:0] row, input logic [2:0] col);
    logic [3:0] r;
    logic [3:0] c;
    case (row)
      4'b0010: r = 4'd1;
      4'b0100: r = 4'd2;
      4'b1000: r = 4'd3;
      default: r = 4'd0;
    endcase
    case (col)
      3'b010:  c = 4'd1;
      3'b100:  c = 4'd2;
      default: c = 4'd0;
    endcase
    return r * 4'd3 + c + 4'd1;
  endfunction

  assign tick       = (div_q == DIV_LAST);
  assign row_onehot = $onehot(key_row);
  assign row_same   = (key_row == row_q);
  assign row_idle   = (key_row == 4'd0);
  // Counters stop at the threshold so they can never wrap.
  assign match_inc  = (match_q == CNT_MAX) ? match_q : match_q + CW'(1);
  assign rel_inc    = (rel_q == CNT_MAX) ? rel_q : rel_q + CW'(1);
  assign col_rot    = {col_q[1:0], col_q[2]};

  // Scan divider: free-running, wraps at SCAN_DIV-1.
  always_ff @(posedge clk) begin
    if (rst)       div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SCAN;
    else     state_q <= state_d;
  end

  // FSM next-state: transitions only happen on scan ticks.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        SCAN:     if (row_onehot) state_d = (DEBOUNCE_SCANS == 1) ? HELD : DEBOUNCE;
        DEBOUNCE: if (!row_same) state_d = SCAN;
                  else if (match_inc == CNT_MAX) state_d = HELD;
        HELD:     if (row_idle && rel_inc == CNT_MAX) state_d = SCAN;
        default:  state_d = SCAN;
      endcase
    end
  end

  // FSM outputs and datapath next values; the column only moves when
  // returning to or staying in SCAN without a clean single-row hit.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    match_d = match_q;
    rel_d   = rel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (row_onehot) begin
            row_d   = key_row;
            match_d = CW'(1);
            rel_d   = '0;
            if (DEBOUNCE_SCANS == 1) begin
              data_d  = key_code(key_row, col_q);
              valid_d = 1'b1;
            end
          end else begin
            col_d = col_rot;
          end
        end
        DEBOUNCE: begin
          if (row_same) begin
            match_d = match_inc;
            if (match_inc == CNT_MAX) begin
              data_d  = key_code(row_q, col_q);
              valid_d = 1'b1;
              rel_d   = '0;
            end
          end else begin
            col_d   = col_rot;
            match_d = '0;
          end
        end
        HELD: begin
          if (row_idle) begin
            rel_d = rel_inc;
            if (rel_inc == CNT_MAX) begin
              col_d   = col_rot;
              rel_d   = '0;
              match_d = '0;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: col_d = col_q;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= 3'b001;
      row_q     <= '0;
      match_q   <= '0;
      rel_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pressed_q <= (state_d == HELD);
    end
  end

  assign key_col     = col_q;
  assign key_data    = data_q;
  assign key_valid   = valid_q;
  assign key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model (set of pressed keys)
// drives key_row from key_col; expected codes are queued on each press and
// a separate monitor checks every key_valid strobe against the queue.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_data;
  logic       key_valid;
  logic       key_pressed;
  logic [12:1] keys = '0;

  int checks = 0, passed = 0;
  int mchecks = 0, mpassed = 0;
  int strobes = 0;
  int rd_idx = 0;
  int exp_q[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .key_data(key_data), .key_valid(key_valid), .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key at (r,c) shorts column c onto row r.
  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (key_col[c] && keys[r*3 + c + 1]) key_row[r] = 1'b1;
  end

  // Monitor: every strobe must match the next queued key and show it held.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && key_valid) begin
        strobes = strobes + 1;
        mchecks = mchecks + 1;
        if (rd_idx >= exp_q.size())
          $display("FAIL unexpected_strobe: key_data=%0d, wanted no strobe", key_data);
        else begin
          if (int'(key_data) == exp_q[rd_idx] && key_pressed) mpassed = mpassed + 1;
          else $display("FAIL strobe_code: key_data=%0d pressed=%0d, wanted %0d pressed=1",
                        key_data, key_pressed, exp_q[rd_idx]);
          rd_idx = rd_idx + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, wanted %0d", name, act, req);
  endtask

  task automatic press(input int k, input bit expect_strobe);
    @(negedge clk);
    if (expect_strobe) exp_q.push_back(k);
    keys[k] = 1'b1;
  endtask

  // Wait (bounded) until the monitor has seen every queued strobe.
  task automatic wait_strobe(input string name);
    for (int i = 0; i < 200 && strobes < exp_q.size(); i++) @(posedge clk);
    @(posedge clk);
    chk(name, strobes, exp_q.size());
  endtask

  // Release every key at a negedge; n = negedges until key_pressed drops.
  task automatic release_all(output int n);
    @(negedge clk);
    keys = '0;
    n = 0;
    while (key_pressed && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col"}, key_col, 3'b001);
    chk({tag, "_data"}, key_data, 0);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_pressed"}, key_pressed, 0);
  endtask

  initial begin
    logic [2:0] prev, expc;
    int last, n, vhigh, chg;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Idle: column rotates every SCAN_DIV clocks, never a strobe
    prev = 3'b001; last = 0; vhigh = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (key_valid) vhigh = 1;
      if (key_col != prev) begin
        expc = {prev[1:0], prev[2]};
        chk("idle_interval", k - last, SD);
        chk("idle_rotate", key_col, expc);
        prev = key_col;
        last = k;
      end
    end
    chk("idle_no_valid", vhigh, 0);

    // Key '5' held for 12 ticks, then released
    press(5, 1);
    wait_strobe("k5_strobe");
    repeat (12 * SD) @(posedge clk);
    chk("k5_single_strobe", strobes, exp_q.size());
    @(negedge clk);
    chk("k5_data", key_data, 5);
    chk("k5_held", key_pressed, 1);
    release_all(n);
    chk("k5_release_latency", int'(n >= 9 && n <= 12), 1);
    chk("k5_data_kept", key_data, 5);

    // Bounce: two matches, one drop, then a clean hold on a later scan
    n = 0;
    while (key_col == 3'b010 && n < 40) begin @(negedge clk); n++; end
    while (key_col != 3'b010 && n < 40) begin @(negedge clk); n++; end
    chk("bounce_sync", int'(n < 40), 1);
    keys[5] = 1'b1;
    repeat (2 * SD) @(posedge clk);
    #1 keys[5] = 1'b0;
    repeat (SD) @(posedge clk);
    @(negedge clk);
    chk("bounce_no_strobe", strobes, exp_q.size());
    chk("bounce_col_rotated", key_col, 3'b100);
    chk("bounce_not_held", key_pressed, 0);
    press(5, 1);
    wait_strobe("bounce_retry_strobe");
    release_all(n);
    chk("bounce_released", key_pressed, 0);

    // Ghost: two rows on col0 ignored, scan continues; then '#'
    @(negedge clk);
    keys[1] = 1'b1; keys[4] = 1'b1;
    vhigh = 0; chg = 0; prev = key_col;
    for (int k = 0; k < 12 * SD; k++) begin
      @(negedge clk);
      if (key_valid || key_pressed) vhigh = 1;
      if (key_col != prev) chg++;
      prev = key_col;
    end
    chk("ghost_ignored", vhigh, 0);
    chk("ghost_scan_runs", int'(chg >= 10), 1);
    release_all(n);
    press(12, 1);
    wait_strobe("hash_strobe");
    @(negedge clk);
    chk("hash_data", key_data, 12);
    release_all(n);

    // Reset while '9' is held, then re-acquire with it still held
    press(9, 1);
    wait_strobe("k9_strobe");
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst = 1'b0;
    n = 0;
    while (key_col == 3'b001 && n < 20) begin @(negedge clk); n++; end
    chk("rst_first_tick", n, SD);
    exp_q.push_back(9);
    wait_strobe("k9_reacquire");
    @(negedge clk);
    chk("k9_data", key_data, 9);
    release_all(n);

    // '1' held, '3' added: no second strobe until full release
    press(1, 1);
    wait_strobe("k1_strobe");
    @(negedge clk);
    keys[3] = 1'b1;
    repeat (10 * SD) @(posedge clk);
    chk("k1k3_no_second", strobes, exp_q.size());
    @(negedge clk);
    chk("k1k3_data", key_data, 1);
    release_all(n);
    repeat (DB * SD) @(posedge clk);
    press(3, 1);
    wait_strobe("k3_strobe");
    @(negedge clk);
    chk("k3_data", key_data, 3);
    release_all(n);

    // Random presses of random keys with random hold/idle lengths
    for (int i = 0; i < 8; i++) begin
      int k;
      k = $urandom_range(12, 1);
      press(k, 1);
      wait_strobe("rand_strobe");
      repeat ($urandom_range(30, 0)) @(posedge clk);
      @(negedge clk);
      chk("rand_data", key_data, k);
      release_all(n);
      chk("rand_released", key_pressed, 0);
      repeat ($urandom_range(10, 0)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    chk("all_strobes_seen", rd_idx, exp_q.size());
    $display("%0d/%0d checks passed", passed + mpassed, checks + mchecks);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter SCAN_DIV SHALL default to 25000 and set the number of clk cycles per scan tick (legal values >= 2).
REQ-003 Parameter DEBOUNCE_SCANS SHALL default to 4 and set the number of consecutive matching samples needed to accept a press or a release (legal values >= 1).
REQ-004 The ports SHALL be, clock and reset first:
  clk  input  1  system clock
  rst  input  1  synchronous active-high reset
  key_row  input  4  keypad row sense, active-high, synchronous to clk
  key_col  output  3  column drive, one-hot, active-high
  key_data  output  4  last accepted key code: 0 = none, 1..9 = board cells, 10 = '*', 11 = '0', 12 = '#'
  key_valid  output  1  one-cycle strobe on each accepted press
  key_pressed  output  1  high while an accepted key is held

Function
REQ-005 A divider counter SHALL count 0..SCAN_DIV-1 and wrap; the scan tick SHALL be high for one cycle when the counter equals SCAN_DIV-1.
REQ-006 The block SHALL process key_row only on tick cycles, and it SHALL sample key_row against the column currently driven.
REQ-007 The key code for column c (0..2) and row r (0..3) SHALL be r*3 + c + 1.
REQ-008 The FSM SHALL have exactly these states: SCAN, DEBOUNCE, HELD.
REQ-009 SCAN, on a tick:
  - Exactly one key_row bit high: latch row pattern and column, set match count to 1, go to DEBOUNCE, keep key_col unchanged.
  - Otherwise (zero bits, or two or more bits high): rotate key_col 001 -> 010 -> 100 -> 001.
REQ-010 DEBOUNCE, on a tick:
  - key_row equals the latched pattern: increment match count.
  - Any mismatch: go to SCAN and rotate key_col.
REQ-011 When the match count reaches DEBOUNCE_SCANS, on that same clock edge the block SHALL:
  - load key_data with the code;
  - assert key_valid for exactly one cycle;
  - go to HELD with the release count at 0.
REQ-012 With DEBOUNCE_SCANS = 1, the block SHALL go from SCAN directly to HELD on the first valid tick and emit key_valid at that edge.
REQ-013 HELD, on a tick:
  - key_row = 0: increment release count.
  - key_row != 0: clear release count.
  - Release count reaching DEBOUNCE_SCANS: go to SCAN, rotate key_col, emit no strobe.
REQ-014 key_col SHALL stay frozen throughout DEBOUNCE and HELD.
REQ-015 key_pressed SHALL be high exactly while the FSM is in HELD.
REQ-016 key_data SHALL hold its value until the next accepted press, including across releases.
REQ-017 The block SHALL emit no key_valid on a press of a second key while in HELD; only a full release followed by a new press produces a new strobe.
REQ-018 The block SHALL emit key_valid at most once per accepted press, regardless of hold duration.
REQ-019 The match and release counters SHALL saturate and never wrap.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 While rst is high at a clk edge, the block SHALL set:
  - state = SCAN, divider = 0, match and release counts = 0;
  - key_col = 001, key_data = 0, key_valid = 0, key_pressed = 0.
REQ-022 A reset asserted mid-DEBOUNCE or mid-HELD SHALL abort with no strobe, and the first tick after reset release SHALL occur SCAN_DIV cycles later.

Verification (SCAN_DIV = 4, DEBOUNCE_SCANS = 3)
REQ-023 Idle: key_row = 0 for 40 cycles -> key_col cycles 001, 010, 100 every 4 clk; key_valid never high.
REQ-024 Key '5' (row1, col1) held for 12 ticks:
  - key_data = 5, with one key_valid pulse at the 3rd matching tick;
  - key_pressed high until 3 ticks after release.
REQ-025 Bounce: row1 matches for 2 ticks, drops for 1, then holds -> no strobe from the first attempt; strobe only after 3 new consecutive matches on a later scan of col1.
REQ-026 Ghost: key_row = 0011 at col0 -> ignored and the scan continues; then key_row = 1000 at col2 for 3 ticks -> key_data = 12.
REQ-027 Reset in HELD with key '9' held:
  - all outputs return to reset values;
  - with '9' still held after reset, a new press is accepted and key_data = 9 after 3 ticks.
REQ-028 Key '1' held, then '3' pressed without releasing '1' -> no second strobe; after full release for 3 ticks and a press of '3' -> key_data = 3.
